// File: rtl/st_align_if.sv
// Store-side bus bundle for st_align: MEM-stage store request plus dmem write port.
// st_misaligned exists only when ST_MISALIGN_TRAP_EN is defined.
interface st_align_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [2:0]        st_funct3;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_we;
    logic              mem_ack;
    logic              st_done;
    logic              st_err;
`ifdef ST_MISALIGN_TRAP_EN
    logic              st_misaligned;
`endif

    // master: the core/memory environment; slave: the aligner itself.
    modport master (
        output st_valid, st_addr, st_data, st_funct3, mem_req_ready, mem_ack,
        input  st_ready, mem_req_valid, mem_addr, mem_wdata, mem_we, st_done, st_err
`ifdef ST_MISALIGN_TRAP_EN
        , input st_misaligned
`endif
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, mem_req_ready, mem_ack,
        output st_ready, mem_req_valid, mem_addr, mem_wdata, mem_we, st_done, st_err
`ifdef ST_MISALIGN_TRAP_EN
        , output st_misaligned
`endif
    );
endinterface

// File: rtl/st_align.sv
// Store aligner: captures a store, lane-aligns data/byte-enables and runs the dmem write handshake.
// Optional misaligned-store trap is enabled by defining ST_MISALIGN_TRAP_EN.
module st_align #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst_n,
    st_align_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
`ifdef ST_MISALIGN_TRAP_EN
        , TRAP   = 2'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       sb_wdata;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_we;
    logic [1:0]        off;
    logic              timeout_hit;
    logic              misalign_cap;

    assign off = bus.st_addr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sb_lane
            assign sb_wdata[8*gi +: 8] = bus.st_data[7:0];
        end
    endgenerate

    always_comb begin
        lane_we    = 4'b1111;
        lane_wdata = bus.st_data;
        case (bus.st_funct3)
            3'b000: begin
                lane_we    = 4'b0001 << off;
                lane_wdata = sb_wdata;
            end
            3'b001: begin
                // Offset 11 falls back to the upper half, matching the load-side rule.
                case (off)
                    2'b00: begin
                        lane_we    = 4'b0011;
                        lane_wdata = {16'h0000, bus.st_data[15:0]};
                    end
                    2'b01: begin
                        lane_we    = 4'b0110;
                        lane_wdata = {8'h00, bus.st_data[15:0], 8'h00};
                    end
                    default: begin
                        lane_we    = 4'b1100;
                        lane_wdata = {bus.st_data[15:0], 16'h0000};
                    end
                endcase
            end
            default: ;
        endcase
    end

`ifdef ST_MISALIGN_TRAP_EN
    assign misalign_cap = (bus.st_funct3 == 3'b001) ? off[0] :
                          (bus.st_funct3 != 3'b000) && (off != 2'b00);
`else
    assign misalign_cap = 1'b0;
`endif

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // cnt_q counts completed WAIT_ACK cycles, so the current cycle number is cnt_q+1.
            assign timeout_hit = (state_q == WAIT_ACK) && (cnt_q == CNT_W'(TIMEOUT - 1));

            always_comb begin
                cnt_d = '0;
                if (state_q == WAIT_ACK) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        we_d               = we_q;
        bus.st_ready       = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.st_done        = 1'b0;
        bus.st_err         = 1'b0;
`ifdef ST_MISALIGN_TRAP_EN
        bus.st_misaligned  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bus.st_ready = 1'b1;
                if (bus.st_valid) begin
                    addr_d  = bus.st_addr[ADDR_W-1:2];
                    wdata_d = lane_wdata;
                    we_d    = lane_we;
`ifdef ST_MISALIGN_TRAP_EN
                    state_d = misalign_cap ? TRAP : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    if (bus.mem_ack) begin
                        bus.st_done = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d     = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.mem_ack) begin
                    bus.st_done = 1'b1;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    bus.st_err  = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef ST_MISALIGN_TRAP_EN
            TRAP: begin
                bus.st_misaligned = 1'b1;
                state_d           = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Byte enables are gated so they can only be seen alongside a live request.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ISSUE) ? we_q : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    logic unused_ok;
    assign unused_ok = misalign_cap;

endmodule

// File: tb/tb_st_align.sv
// Directed self-checking bench for st_align (default TIMEOUT=15, ADDR_W=32).
// Extra misaligned-store checks run when ST_MISALIGN_TRAP_EN is defined.
module tb_st_align;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    st_align_if #(.ADDR_W(32)) bus();

    st_align #(.ADDR_W(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one store for a single cycle; returns #1 after the capture edge (state ISSUE).
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                         input logic rdy, input logic ack);
        bus.st_valid      = 1'b1;
        bus.st_addr       = addr;
        bus.st_data       = data;
        bus.st_funct3     = f3;
        bus.mem_req_ready = rdy;
        bus.mem_ack       = ack;
        cyc();
        bus.st_valid      = 1'b0;
        #1;
        $display("store addr=%h data=%h f3=%0d -> mem_addr=%h we=%b wdata=%h", addr, data, f3,
                 bus.mem_addr, bus.mem_we, bus.mem_wdata);
    endtask

    initial begin
        bus.st_valid      = 1'b0;
        bus.st_addr       = '0;
        bus.st_data       = '0;
        bus.st_funct3     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_ack       = 1'b0;
        #2;
        chk("rst_st_ready", 32'(bus.st_ready), 1);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_done", 32'(bus.st_done), 0);
        chk("rst_err", 32'(bus.st_err), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // SB at offset 3, request accepted immediately, ack one cycle later
        store(32'h103, 32'h0000_00AB, 3'b000, 1'b1, 1'b0);
        chk("sb_req_valid", 32'(bus.mem_req_valid), 1);
        chk("sb_addr", 32'(bus.mem_addr), 32'h40);
        chk("sb_we", 32'(bus.mem_we), 32'b1000);
        chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        chk("sb_ready_busy", 32'(bus.st_ready), 0);
        chk("sb_no_early_done", 32'(bus.st_done), 0);
        cyc();
        chk("sb_wait_req_valid", 32'(bus.mem_req_valid), 0);
        chk("sb_wait_we", 32'(bus.mem_we), 0);
        bus.mem_ack = 1'b1;
        #1;
        chk("sb_done", 32'(bus.st_done), 1);
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("sb_done_pulse_end", 32'(bus.st_done), 0);
        chk("sb_ready_again", 32'(bus.st_ready), 1);

        // SB offset 0, upper data bits must be ignored
        store(32'h100, 32'hFFFF_FFCD, 3'b000, 1'b1, 1'b1);
        chk("sb0_we", 32'(bus.mem_we), 32'b0001);
        chk("sb0_wdata", bus.mem_wdata, 32'hCDCD_CDCD);
        chk("sb0_same_cycle_done", 32'(bus.st_done), 1);
        cyc();

        // SH at each offset class; ready and ack arrive together in ISSUE
        store(32'h201, 32'hFFFF_1234, 3'b001, 1'b1, 1'b1);
        chk("sh1_addr", 32'(bus.mem_addr), 32'h80);
        chk("sh1_we", 32'(bus.mem_we), 32'b0110);
        chk("sh1_wdata", bus.mem_wdata, 32'h0012_3400);
        chk("sh1_done", 32'(bus.st_done), 1);
        cyc();
        chk("sh1_ready", 32'(bus.st_ready), 1);
        store(32'h203, 32'hFFFF_1234, 3'b001, 1'b1, 1'b1);
        chk("sh3_we", 32'(bus.mem_we), 32'b1100);
        chk("sh3_wdata", bus.mem_wdata, 32'h1234_0000);
        cyc();
        store(32'h200, 32'hFFFF_1234, 3'b001, 1'b1, 1'b1);
        chk("sh0_we", 32'(bus.mem_we), 32'b0011);
        chk("sh0_wdata", bus.mem_wdata, 32'h0000_1234);
        cyc();

        // Unknown funct3 behaves as SW
        store(32'h10, 32'h0102_0304, 3'b011, 1'b1, 1'b1);
        chk("oth_we", 32'(bus.mem_we), 32'b1111);
        chk("oth_wdata", bus.mem_wdata, 32'h0102_0304);
        chk("oth_addr", 32'(bus.mem_addr), 32'h4);
        cyc();

        // SW with backpressure: outputs must stay stable while ready is low
        store(32'h8, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sw_hold_valid", 32'(bus.mem_req_valid), 1);
            chk("sw_hold_we", 32'(bus.mem_we), 32'b1111);
            chk("sw_hold_addr", 32'(bus.mem_addr), 32'h2);
            chk("sw_hold_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            if (i < 2) cyc();
        end
        cyc();
        bus.mem_req_ready = 1'b1;
        #1;
        chk("sw_accept_valid", 32'(bus.mem_req_valid), 1);
        cyc();
        chk("sw_wait_valid", 32'(bus.mem_req_valid), 0);
        bus.mem_ack = 1'b1;
        #1;
        chk("sw_done", 32'(bus.st_done), 1);
        cyc();
        bus.mem_ack = 1'b0;

        // Timeout: no ack for 15 WAIT_ACK cycles
        store(32'h20, 32'h5555_AAAA, 3'b010, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("to_err", 32'(bus.st_err), (k == 15) ? 1 : 0);
        end
        $display("timeout: st_err=%b in WAIT_ACK cycle 15", bus.st_err);
        chk("to_no_done", 32'(bus.st_done), 0);
        cyc();
        chk("to_ready_after", 32'(bus.st_ready), 1);
        chk("to_err_pulse_end", 32'(bus.st_err), 0);

        // Ack arriving exactly on timeout cycle wins
        store(32'h24, 32'h1111_2222, 3'b010, 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) cyc();
        cyc();
        bus.mem_ack = 1'b1;
        #1;
        chk("to_ack_done", 32'(bus.st_done), 1);
        chk("to_ack_no_err", 32'(bus.st_err), 0);
        cyc();
        bus.mem_ack = 1'b0;

        // Reset during WAIT_ACK aborts the store
        store(32'h30, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("rstw_ready", 32'(bus.st_ready), 1);
        chk("rstw_addr", 32'(bus.mem_addr), 0);
        chk("rstw_wdata", bus.mem_wdata, 0);
        chk("rstw_we", 32'(bus.mem_we), 0);
        chk("rstw_req_valid", 32'(bus.mem_req_valid), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        bus.mem_ack = 1'b1;
        #1;
        chk("rstw_late_ack_no_done", 32'(bus.st_done), 0);
        cyc();
        bus.mem_ack = 1'b0;
        $display("reset abort: late ack st_done=%b", bus.st_done);

`ifdef ST_MISALIGN_TRAP_EN
        // Misaligned SW traps without touching memory
        store(32'h6, 32'h0BAD_0BAD, 3'b010, 1'b1, 1'b1);
        chk("mis_pulse", 32'(bus.st_misaligned), 1);
        chk("mis_no_req", 32'(bus.mem_req_valid), 0);
        chk("mis_no_done", 32'(bus.st_done), 0);
        cyc();
        chk("mis_pulse_end", 32'(bus.st_misaligned), 0);
        chk("mis_ready", 32'(bus.st_ready), 1);
        chk("mis_still_no_req", 32'(bus.mem_req_valid), 0);
        // Halfword-aligned SH at offset 2 is legal
        store(32'h6, 32'h0000_BEEF, 3'b001, 1'b1, 1'b1);
        chk("mis_sh_no_trap", 32'(bus.st_misaligned), 0);
        chk("mis_sh_we", 32'(bus.mem_we), 32'b1100);
        chk("mis_sh_wdata", bus.mem_wdata, 32'hBEEF_0000);
        chk("mis_sh_done", 32'(bus.st_done), 1);
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
